// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs, status codes
// and the D pipeline-register layout with its bubble value.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
  } d_reg_t;

  localparam d_reg_t D_BUBBLE = '{stat: SAOK, icode: INOP, ifun: 4'h0,
                                  rA: RNONE, rB: RNONE,
                                  valC: 64'd0, valP: 64'd0};

  // RNONE is never a forwarding match, whatever the producer reports.
  function automatic logic src_hit(input logic [3:0] src, input logic [3:0] dst);
    return (src != RNONE) && (src == dst);
  endfunction

endpackage

// File: rtl/regfile_y86.sv
// Y86-64 architectural register file: two posedge write ports (M port wins on
// a same-register collision), two combinational read ports, async reset.
module regfile_y86
  import y86_pkg::*;
#(
  parameter int          NREGS     = 15,
  parameter logic [63:0] RESET_RSP = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  dstE_i,
  input  logic [63:0] valE_i,
  input  logic [3:0]  dstM_i,
  input  logic [63:0] valM_i,
  input  logic [3:0]  srcA_i,
  input  logic [3:0]  srcB_i,
  output logic [63:0] valA_o,
  output logic [63:0] valB_o
);

  logic [63:0] regs_q [NREGS];

  // Write ports; the M write is issued last so it overrides E on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == int'(RRSP)) ? RESET_RSP : 64'd0;
      end
    end else begin
      if (dstE_i != RNONE) regs_q[dstE_i] <= valE_i;
      if (dstM_i != RNONE) regs_q[dstM_i] <= valM_i;
    end
  end

  // Read ports; RNONE reads as zero.
  always_comb begin
    valA_o = 64'd0;
    valB_o = 64'd0;
    if (srcA_i != RNONE) valA_o = regs_q[srcA_i];
    else                 valA_o = 64'd0;
    if (srcB_i != RNONE) valB_o = regs_q[srcB_i];
    else                 valB_o = 64'd0;
  end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 pipelined decode stage: D register, register-ID decode and operand
// forwarding. Define DECODE_FWD_EN to enable the full forwarding chain.
module decode_stage
  import y86_pkg::*;
#(
  parameter int          NREGS     = 15,
  parameter logic [63:0] RESET_RSP = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  f_stat,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [63:0] M_valE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valM,
  output logic [2:0]  d_stat,
  output logic [3:0]  d_icode,
  output logic [3:0]  d_ifun,
  output logic [63:0] d_valC,
  output logic [63:0] d_valA,
  output logic [63:0] d_valB,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  d_dstE,
  output logic [3:0]  d_dstM
);

  d_reg_t      d_q, d_d;
  logic [63:0] rf_valA_s, rf_valB_s;

  // D register next state: stall holds and takes priority over bubble.
  always_comb begin
    d_d = d_q;
    if (D_stall)       d_d = d_q;
    else if (D_bubble) d_d = D_BUBBLE;
    else               d_d = '{stat: f_stat, icode: f_icode, ifun: f_ifun,
                               rA: f_rA, rB: f_rB, valC: f_valC, valP: f_valP};
  end

  // D pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= D_BUBBLE;
    else        d_q <= d_d;
  end

  assign d_stat  = d_q.stat;
  assign d_icode = d_q.icode;
  assign d_ifun  = d_q.ifun;
  assign d_valC  = d_q.valC;

  // Register-ID decode; the cmov condition is resolved later in execute.
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (d_q.icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: d_srcA = d_q.rA;
      IRET, IPOPQ:                    d_srcA = RRSP;
      default:                        d_srcA = RNONE;
    endcase
    case (d_q.icode)
      IRMMOVQ, IMRMOVQ, IOPQ:         d_srcB = d_q.rB;
      ICALL, IRET, IPUSHQ, IPOPQ:     d_srcB = RRSP;
      default:                        d_srcB = RNONE;
    endcase
    case (d_q.icode)
      IRRMOVQ, IIRMOVQ, IOPQ:         d_dstE = d_q.rB;
      ICALL, IRET, IPUSHQ, IPOPQ:     d_dstE = RRSP;
      default:                        d_dstE = RNONE;
    endcase
    case (d_q.icode)
      IMRMOVQ, IPOPQ:                 d_dstM = d_q.rA;
      default:                        d_dstM = RNONE;
    endcase
  end

  regfile_y86 #(.NREGS(NREGS), .RESET_RSP(RESET_RSP)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .dstE_i (W_dstE),
    .valE_i (W_valE),
    .dstM_i (W_dstM),
    .valM_i (W_valM),
    .srcA_i (d_srcA),
    .srcB_i (d_srcB),
    .valA_o (rf_valA_s),
    .valB_o (rf_valB_s)
  );

`ifdef DECODE_FWD_EN
  // valA: valP for jXX/call, then youngest producer first.
  always_comb begin
    d_valA = rf_valA_s;
    if (d_q.icode == IJXX || d_q.icode == ICALL) d_valA = d_q.valP;
    else if (src_hit(d_srcA, e_dstE))           d_valA = e_valE;
    else if (src_hit(d_srcA, M_dstM))           d_valA = m_valM;
    else if (src_hit(d_srcA, M_dstE))           d_valA = M_valE;
    else if (src_hit(d_srcA, W_dstM))           d_valA = W_valM;
    else if (src_hit(d_srcA, W_dstE))           d_valA = W_valE;
    else                                        d_valA = rf_valA_s;
  end

  // valB: same producer priority without the valP select.
  always_comb begin
    d_valB = rf_valB_s;
    if (src_hit(d_srcB, e_dstE))      d_valB = e_valE;
    else if (src_hit(d_srcB, M_dstM)) d_valB = m_valM;
    else if (src_hit(d_srcB, M_dstE)) d_valB = M_valE;
    else if (src_hit(d_srcB, W_dstM)) d_valB = W_valM;
    else if (src_hit(d_srcB, W_dstE)) d_valB = W_valE;
    else                              d_valB = rf_valB_s;
  end
`else
  // Without forwarding the hazard unit stalls every RAW hazard.
  always_comb begin
    d_valA = rf_valA_s;
    if (d_q.icode == IJXX || d_q.icode == ICALL) d_valA = d_q.valP;
    else                                        d_valA = rf_valA_s;
  end

  assign d_valB = rf_valB_s;

  logic unused_fwd_s;
  assign unused_fwd_s = ^{e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM};
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed scoreboard bench for decode_stage; expectations follow the
// forwarding build selected by DECODE_FWD_EN.
module tb_decode_stage;

`ifdef DECODE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [63:0] RSP0 = 64'h1000;
  localparam logic [3:0]  RN   = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  f_stat;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic        D_stall, D_bubble;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [2:0]  d_stat;
  logic [3:0]  d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valC, d_valA, d_valB;

  decode_stage #(.NREGS(15), .RESET_RSP(RSP0)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP), .D_stall(D_stall), .D_bubble(D_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC),
    .d_valA(d_valA), .d_valB(d_valB), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_dstE(d_dstE), .d_dstM(d_dstM)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, srcA, srcB, dstE, dstM;
    logic [63:0] valC, valA, valB;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic push(input string name, input logic [2:0] stat,
                      input logic [3:0] icode, input logic [3:0] ifun,
                      input logic [3:0] srcA, input logic [3:0] srcB,
                      input logic [3:0] dstE, input logic [3:0] dstM,
                      input logic [63:0] valC, input logic [63:0] valA,
                      input logic [63:0] valB);
    exp_t e;
    e.name = name; e.stat = stat; e.icode = icode; e.ifun = ifun;
    e.srcA = srcA; e.srcB = srcB; e.dstE = dstE; e.dstM = dstM;
    e.valC = valC; e.valA = valA; e.valB = valB;
    sb_q.push_back(e);
  endtask

  task automatic push_bubble(input string name);
    push(name, 3'd1, 4'h1, 4'h0, RN, RN, RN, RN, 64'd0, 64'd0, 64'd0);
  endtask

  task automatic drive_f(input logic [2:0] stat, input logic [3:0] icode,
                         input logic [3:0] ifun, input logic [3:0] rA,
                         input logic [3:0] rB, input logic [63:0] valC,
                         input logic [63:0] valP);
    f_stat = stat; f_icode = icode; f_ifun = ifun; f_rA = rA; f_rB = rB;
    f_valC = valC; f_valP = valP;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: outputs are stable mid-cycle, compare every queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_vec++;
      if ({d_stat, d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM, d_valC, d_valA, d_valB} !==
          {e.stat, e.icode, e.ifun, e.srcA, e.srcB, e.dstE, e.dstM, e.valC, e.valA, e.valB}) begin
        n_bad++;
        $display("FAIL %s: got stat=%0h icode=%0h ifun=%0h srcA=%0h srcB=%0h dstE=%0h dstM=%0h valC=%0h valA=%0h valB=%0h ; expected stat=%0h icode=%0h ifun=%0h srcA=%0h srcB=%0h dstE=%0h dstM=%0h valC=%0h valA=%0h valB=%0h",
                 e.name, d_stat, d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM, d_valC, d_valA, d_valB,
                 e.stat, e.icode, e.ifun, e.srcA, e.srcB, e.dstE, e.dstM, e.valC, e.valA, e.valB);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; D_stall = 1'b0; D_bubble = 1'b0;
    e_dstE = RN; M_dstE = RN; M_dstM = RN; W_dstE = RN; W_dstM = RN;
    e_valE = 64'd0; M_valE = 64'd0; m_valM = 64'd0; W_valE = 64'd0; W_valM = 64'd0;
    drive_f(3'd1, 4'h6, 4'h0, 4'h0, 4'h1, 64'd0, 64'h2);
    #1 rst_n = 1'b0;
    #1 push_bubble("reset_assert");
    step(); rst_n = 1'b1;
    push_bubble("reset_release");
    step();
    push("opq_zero", 3'd1, 4'h6, 4'h0, 4'h0, 4'h1, 4'h1, RN, 64'd0, 64'd0, 64'd0);
    drive_f(3'd1, 4'hA, 4'h0, 4'h5, RN, 64'd0, 64'h30);
    step();
    push("pushq_rsp", 3'd1, 4'hA, 4'h0, 4'h5, 4'h4, 4'h4, RN, 64'd0, 64'd0, RSP0);
    W_dstE = 4'h3; W_valE = 64'h55;
    drive_f(3'd1, 4'h2, 4'h0, 4'h3, 4'h7, 64'd0, 64'h40);
    step();
    // Write to r3 in the same cycle it is read: regfile gives the old value.
    W_dstE = 4'h3; W_valE = 64'h66; W_dstM = 4'h2; W_valM = 64'h22;
    push("rrmovq_wr", 3'd1, 4'h2, 4'h0, 4'h3, RN, 4'h7, RN, 64'd0,
         FWD ? 64'h66 : 64'h55, 64'd0);
    drive_f(3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'h50);
    step();
    W_dstE = 4'h2; W_valE = 64'hB; W_dstM = RN;
    e_dstE = 4'h2; e_valE = 64'hA;
    M_dstM = 4'h3; m_valM = 64'hC; M_dstE = 4'h3; M_valE = 64'hD;
    push("fwd_prio", 3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 4'h3, RN, 64'd0,
         FWD ? 64'hA : 64'h22, FWD ? 64'hC : 64'h66);
    drive_f(3'd1, 4'h8, 4'h0, RN, RN, 64'h200, 64'h120);
    step();
    e_dstE = RN; M_dstE = RN; M_dstM = RN; W_dstE = RN;
    push("call", 3'd1, 4'h8, 4'h0, RN, 4'h4, 4'h4, RN, 64'h200, 64'h120, RSP0);
    D_stall = 1'b1;
    drive_f(3'd3, 4'h5, 4'h0, 4'h6, 4'h2, 64'h8, 64'h13a);
    step();
    push("stall_hold", 3'd1, 4'h8, 4'h0, RN, 4'h4, 4'h4, RN, 64'h200, 64'h120, RSP0);
    D_stall = 1'b0; D_bubble = 1'b1;
    step();
    push_bubble("bubble");
    D_stall = 1'b1; D_bubble = 1'b1;
    step();
    push_bubble("stall_over_bubble");
    D_stall = 1'b0; D_bubble = 1'b0;
    step();
    push("mrmovq", 3'd3, 4'h5, 4'h0, RN, 4'h2, RN, 4'h6, 64'h8, 64'd0, 64'hB);
    W_dstE = 4'h4; W_valE = 64'h10; W_dstM = 4'h4; W_valM = 64'h20;
    drive_f(3'd1, 4'hB, 4'h0, 4'h9, RN, 64'd0, 64'h150);
    step();
    W_dstE = RN; W_dstM = RN;
    push("dual_write", 3'd1, 4'hB, 4'h0, 4'h4, 4'h4, 4'h4, 4'h9, 64'd0, 64'h20, 64'h20);
    step();
    rst_n = 1'b0;
    drive_f(3'd1, 4'hA, 4'h0, 4'h3, RN, 64'd0, 64'h30);
    #1 push_bubble("reset_midrun");
    step(); rst_n = 1'b1;
    push_bubble("reset_midrun_hold");
    step();
    push("post_reset_regs", 3'd1, 4'hA, 4'h0, 4'h3, 4'h4, 4'h4, RN, 64'd0, 64'd0, RSP0);
    drive_f(3'd1, 4'h7, 4'h3, RN, RN, 64'h400, 64'h160);
    step();
    push("jxx_valp", 3'd1, 4'h7, 4'h3, RN, RN, RN, RN, 64'h400, 64'h160, 64'd0);
    drive_f(3'd1, 4'h3, 4'h0, RN, 4'h8, 64'h77, 64'h16a);
    step();
    e_valE = 64'h99;
    push("irmovq_rnone", 3'd1, 4'h3, 4'h0, RN, RN, 4'h8, RN, 64'h77, 64'd0, 64'd0);
    drive_f(3'd1, 4'h9, 4'h0, RN, RN, 64'd0, 64'h16b);
    step();
    e_valE = 64'd0;
    push("ret", 3'd1, 4'h9, 4'h0, 4'h4, 4'h4, 4'h4, RN, 64'd0, RSP0, RSP0);
    step();
    step();
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
